// File: rtl/jpeg_zigzag_pkg.sv
// Shared types and constants for the JPEG zig-zag serializer: coefficient
// type, read-side state encoding and the zig-zag scan table.
package jpeg_zigzag_pkg;

  localparam int COEFF_W = 11;

  typedef logic signed [COEFF_W-1:0] coeff_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_e;

  // Row-major block index (8*row + col) of the coefficient emitted at scan position k
  localparam logic [5:0] ZZ_ORDER [0:63] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/zz_pingpong_buf.sv
// Two-entry block store for the zig-zag serializer. A whole 8x8 block is
// captured in one cycle into the write-side buffer while the read side scans
// the other one. Tracks how many buffers hold unread blocks and flags drops.
module zz_pingpong_buf
  import jpeg_zigzag_pkg::*;
#(
  parameter int DATA_W = COEFF_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid_i,
  input  logic [0:7][0:7][DATA_W-1:0]   in_block_i,
  input  logic                          release_i,
  input  logic [5:0]                    rd_addr_i,
  output logic                          in_ready_o,
  output logic                          accept_o,
  output logic                          overflow_o,
  output logic [1:0]                    cnt_o,
  output logic [DATA_W-1:0]             rd_data_o
);

  logic [DATA_W-1:0] bufMem_q [2][64];
  logic              wrSel_q;
  logic              rdSel_q;
  logic [1:0]        cnt_q;
  logic [1:0]        cnt_d;
  logic              overflow_q;

  // A buffer is free unless both hold unread blocks; a buffer released this
  // same cycle is deliberately not counted as free yet.
  assign in_ready_o = (cnt_q != 2'd2);
  assign accept_o   = in_valid_i && in_ready_o;
  assign overflow_o = overflow_q;
  assign cnt_o      = cnt_q;
  assign rd_data_o  = bufMem_q[rdSel_q][rd_addr_i];

  // Fill count moves up on accept, down on release, and stays put when both happen together
  always_comb begin
    cnt_d = cnt_q;
    unique case ({accept_o, release_i})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Capture the full incoming block into the write-side buffer in one cycle
  always_ff @(posedge clk) begin
    if (accept_o) begin
      for (int i = 0; i < 64; i++) begin
        bufMem_q[wrSel_q][i[5:0]] <= in_block_i[i[5:3]][i[2:0]];
      end
    end
  end

  // Buffer pointers, fill count and the sticky drop flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrSel_q    <= 1'b0;
      rdSel_q    <= 1'b0;
      cnt_q      <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (accept_o) begin
        wrSel_q <= ~wrSel_q;
      end
      if (release_i) begin
        rdSel_q <= ~rdSel_q;
      end
      if (in_valid_i && !in_ready_o) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/zigzag_serializer.sv
// Streams each buffered 8x8 quantized block out as 64 coefficients in JPEG
// zig-zag order over a valid/ready handshake. The block store lives in
// zz_pingpong_buf; this level owns the read FSM, scan counter and output mux.
module zigzag_serializer
  import jpeg_zigzag_pkg::*;
#(
  parameter int DATA_W = COEFF_W
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  input  logic signed [0:7][0:7][DATA_W-1:0] in_block,
  output logic                               in_ready,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic signed [DATA_W-1:0]           out_data,
  output logic [5:0]                         out_index,
  output logic                               out_first,
  output logic                               out_last,
  output logic                               overflow
);

  rd_state_e         state_q;
  logic [5:0]        k_q;
  logic              acceptPulse;
  logic              releaseBeat;
  logic [1:0]        fillCnt;
  logic [DATA_W-1:0] rdData;

  zz_pingpong_buf #(
    .DATA_W (DATA_W)
  ) uPingPong (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid),
    .in_block_i (in_block),
    .release_i  (releaseBeat),
    .rd_addr_i  (ZZ_ORDER[k_q]),
    .in_ready_o (in_ready),
    .accept_o   (acceptPulse),
    .overflow_o (overflow),
    .cnt_o      (fillCnt),
    .rd_data_o  (rdData)
  );

  // The final beat of a block frees its buffer
  assign releaseBeat = (state_q == STREAM) && out_ready && (k_q == 6'd63);

  // Outputs depend only on the FSM, the scan counter and the stored block,
  // so they stay put while the consumer stalls
  assign out_valid = (state_q == STREAM);
  assign out_index = k_q;
  assign out_first = (state_q == STREAM) && (k_q == 6'd0);
  assign out_last  = (state_q == STREAM) && (k_q == 6'd63);
  assign out_data  = (state_q == STREAM) ? $signed(rdData) : '0;

  // Read FSM and scan counter; an accept seen in IDLE starts streaming on the
  // very next cycle, and a block waiting at the final beat follows with no gap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= 6'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          k_q <= 6'd0;
          if (acceptPulse || (fillCnt != 2'd0)) begin
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (k_q == 6'd63) begin
              k_q <= 6'd0;
              if (!((fillCnt == 2'd2) || acceptPulse)) begin
                state_q <= IDLE;
              end
            end else begin
              k_q <= k_q + 6'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          k_q     <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zigzag_serializer.sv
// Directed bench for zigzag_serializer: ramp blocks, back-to-back streaming,
// drop on full, random stalls, mid-stream reset and extreme values.
module tb_zigzag_serializer;

  localparam int DATA_W = 11;

  logic                               clk = 1'b0;
  logic                               rst;
  logic                               in_valid;
  logic signed [0:7][0:7][DATA_W-1:0] inBlock;
  logic                               in_ready;
  logic                               out_valid;
  logic                               out_ready;
  logic signed [DATA_W-1:0]           out_data;
  logic [5:0]                         out_index;
  logic                               out_first;
  logic                               out_last;
  logic                               overflow;

  int vectors     = 0;
  int miscompares = 0;
  int curBeat     = 0;

  // Expected scan order, transcribed by hand from the JPEG zig-zag pattern
  int zzTab [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  int expBlk [2][64];

  zigzag_serializer #(
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_block  (inBlock),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_first (out_first),
    .out_last  (out_last),
    .overflow  (overflow)
  );

  // Free-running 100 MHz-style clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s (beat %0d): observed %0d expected %0d", tag, curBeat, observed, expected);
    end
  endtask

  // Drive inputs now, let one rising edge pass, return at the next falling edge
  task automatic applyStimulus(input logic vld, input logic rdy);
    in_valid  = vld;
    out_ready = rdy;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic checkBeat(input int k, input int expData);
    curBeat = k;
    checkOutput("outValid", out_valid, 1);
    checkOutput("outIndex", out_index, k);
    checkOutput("outData", out_data, expData);
    checkOutput("outFirst", out_first, (k == 0) ? 1 : 0);
    checkOutput("outLast", out_last, (k == 63) ? 1 : 0);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "Valid"}, out_valid, 0);
    checkOutput({tag, "Data"}, out_data, 0);
    checkOutput({tag, "Index"}, out_index, 0);
    checkOutput({tag, "First"}, out_first, 0);
    checkOutput({tag, "Last"}, out_last, 0);
  endtask

  task automatic loadRamp(input int slot, input int offset);
    for (int i = 0; i < 64; i++) begin
      inBlock[i / 8][i % 8] = DATA_W'(offset + i);
      expBlk[slot][i]       = offset + i;
    end
  endtask

  task automatic loadRandom(input int slot);
    int val;
    for (int i = 0; i < 64; i++) begin
      val = int'($urandom_range(0, 2047)) - 1024;
      if (i == 0) val = -1024;
      if (i == 1) val = 1023;
      inBlock[i / 8][i % 8] = DATA_W'(val);
      expBlk[slot][i]       = val;
    end
  endtask

  initial begin
    int  k;
    int  cycles;
    logic rdy;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    inBlock   = '0;
    #2;
    // Reset values while reset is held
    checkIdle("rst");
    checkOutput("rstOverflow", overflow, 0);
    checkOutput("rstInReady", in_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single ramp block with the consumer always ready
    $display("[TB] single ramp block");
    loadRamp(0, 0);
    applyStimulus(1'b1, 1'b1);
    for (int b = 0; b < 64; b++) begin
      checkBeat(b, expBlk[0][zzTab[b]]);
      applyStimulus(1'b0, 1'b1);
    end
    checkOutput("rampIdleAfter", out_valid, 0);

    // Second block arrives at beat 10 of the first; expect 128 unbroken beats
    $display("[TB] back-to-back ramp blocks");
    loadRamp(0, 0);
    applyStimulus(1'b1, 1'b1);
    for (int blk = 0; blk < 2; blk++) begin
      for (int b = 0; b < 64; b++) begin
        checkBeat(b, expBlk[blk][zzTab[b]]);
        if (blk == 0 && b == 10) begin
          loadRamp(1, 100);
          applyStimulus(1'b1, 1'b1);
        end else begin
          applyStimulus(1'b0, 1'b1);
        end
      end
    end
    checkOutput("b2bIdleAfter", out_valid, 0);

    // Consumer stalled: two blocks fill both buffers, the third is dropped
    $display("[TB] overflow on full");
    checkOutput("preOverflow", overflow, 0);
    loadRamp(0, 200);
    applyStimulus(1'b1, 1'b0);
    checkOutput("fullInReady1", in_ready, 1);
    checkOutput("fullValid1", out_valid, 1);
    loadRamp(1, 300);
    applyStimulus(1'b1, 1'b0);
    checkOutput("fullInReady2", in_ready, 0);
    checkOutput("fullOverflow2", overflow, 0);
    loadRamp(0, 500);
    for (int i = 0; i < 64; i++) expBlk[0][i] = 200 + i;
    applyStimulus(1'b1, 1'b0);
    checkOutput("fullOverflow3", overflow, 1);
    checkOutput("fullInReady3", in_ready, 0);
    for (int blk = 0; blk < 2; blk++) begin
      for (int b = 0; b < 64; b++) begin
        checkBeat(b, expBlk[blk][zzTab[b]]);
        applyStimulus(1'b0, 1'b1);
      end
    end
    checkOutput("fullIdleAfter", out_valid, 0);
    checkOutput("fullOverflowSticky", overflow, 1);

    // Random block with random consumer stalls; index and data must hold while stalled
    $display("[TB] random block with stalls");
    loadRandom(0);
    applyStimulus(1'b1, 1'b0);
    k      = 0;
    cycles = 0;
    while (k < 64 && cycles < 400) begin
      checkBeat(k, expBlk[0][zzTab[k]]);
      rdy = 1'($urandom_range(0, 1));
      applyStimulus(1'b0, rdy);
      if (rdy) k++;
      cycles++;
    end
    checkOutput("randDrainCount", k, 64);
    checkOutput("randIdleAfter", out_valid, 0);

    // Reset at beat 30 of block A while block B waits; neither may reappear
    $display("[TB] reset mid-stream");
    loadRamp(0, 0);
    applyStimulus(1'b1, 1'b1);
    for (int b = 0; b <= 30; b++) begin
      checkBeat(b, expBlk[0][zzTab[b]]);
      if (b == 30) break;
      if (b == 5) begin
        loadRamp(1, 100);
        applyStimulus(1'b1, 1'b1);
      end else begin
        applyStimulus(1'b0, 1'b1);
      end
    end
    rst = 1'b1;
    #1;
    checkIdle("midRst");
    checkOutput("midRstOverflow", overflow, 0);
    checkOutput("midRstInReady", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1);
    checkOutput("postRstValid1", out_valid, 0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("postRstValid2", out_valid, 0);
    loadRamp(0, 700);
    applyStimulus(1'b1, 1'b1);
    for (int b = 0; b < 64; b++) begin
      checkBeat(b, expBlk[0][zzTab[b]]);
      applyStimulus(1'b0, 1'b1);
    end
    checkOutput("postRstIdleAfter", out_valid, 0);

    // All -1 except the final coefficient at the positive limit
    $display("[TB] negative block with max last coefficient");
    for (int i = 0; i < 64; i++) begin
      inBlock[i / 8][i % 8] = (i == 63) ? DATA_W'(1023) : DATA_W'(-1);
      expBlk[0][i]          = (i == 63) ? 1023 : -1;
    end
    applyStimulus(1'b1, 1'b1);
    for (int b = 0; b < 64; b++) begin
      checkBeat(b, expBlk[0][zzTab[b]]);
      applyStimulus(1'b0, 1'b1);
    end
    checkOutput("negIdleAfter", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
